// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - sequential signed restoring divider with sign correction
// Optional zero-divisor shortcut and flag enabled by BOOTH_DIV_ZERO_CHECK_EN.
module booth_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH:0]   r_rem;
   logic [WIDTH:0]   r_div_mag;
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_zero;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;

   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_b_ext;
   logic [WIDTH:0]   w_a_mag;
   logic [WIDTH:0]   w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_trial_ok;
   logic             w_last;
   logic             w_zero_skip;
   logic [WIDTH-1:0] w_rem_low;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;
   logic             w_unused;

   // Magnitudes need WIDTH+1 bits so that -2^(WIDTH-1) has a positive form.
   assign w_a_ext = {dividend[WIDTH-1], dividend};
   assign w_b_ext = {divisor[WIDTH-1], divisor};
   assign w_a_mag = w_a_ext[WIDTH] ? ((WIDTH+1)'(0) - w_a_ext) : w_a_ext;
   assign w_b_mag = w_b_ext[WIDTH] ? ((WIDTH+1)'(0) - w_b_ext) : w_b_ext;

`ifdef BOOTH_DIV_ZERO_CHECK_EN
   assign w_zero_skip = ~|divisor;
`else
   assign w_zero_skip = 1'b0;
`endif

   // One restoring step: shift the next dividend bit in, keep the trial if it did not go negative.
   assign w_shift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_trial    = {1'b0, w_shift} - {1'b0, r_div_mag};
   assign w_trial_ok = ~w_trial[WIDTH+1];
   assign w_last     = (r_cnt == CW'(WIDTH-1));

   assign w_rem_low = r_rem[WIDTH-1:0];
   assign w_q_fix   = r_zero ? {WIDTH{1'b1}}
                             : ((r_sign_a ^ r_sign_b) ? (WIDTH'(0) - r_q) : r_q);
   assign w_r_fix   = r_sign_a ? (WIDTH'(0) - w_rem_low) : w_rem_low;

   // Remainder never exceeds 2^(WIDTH-1), so the top magnitude bits carry no information.
   assign w_unused = ^{r_rem[WIDTH], w_a_mag[WIDTH]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = w_zero_skip ? S_FIX : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next = S_FIX;
            end
         end
         S_FIX:   w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem         <= '0;
         r_div_mag     <= '0;
         r_q           <= '0;
         r_cnt         <= '0;
         r_sign_a      <= 1'b0;
         r_sign_b      <= 1'b0;
         r_zero        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sign_a      <= dividend[WIDTH-1];
                  r_sign_b      <= divisor[WIDTH-1];
                  r_div_mag     <= w_b_mag;
                  r_cnt         <= '0;
                  r_zero        <= w_zero_skip;
                  r_div_by_zero <= 1'b0;
                  if (w_zero_skip) begin
                     r_q   <= {WIDTH{1'b1}};
                     r_rem <= w_a_mag;
                  end else begin
                     r_q   <= w_a_mag[WIDTH-1:0];
                     r_rem <= '0;
                  end
               end
            end
            S_RUN: begin
               r_q   <= {r_q[WIDTH-2:0], w_trial_ok};
               r_rem <= w_trial_ok ? w_trial[WIDTH:0] : w_shift;
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               r_quotient    <= w_q_fix;
               r_remainder   <= w_r_fix;
               r_div_by_zero <= r_zero;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy        = (r_state == S_RUN) || (r_state == S_FIX);
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - directed self-checking bench for booth_divider (WIDTH=8)
module tb_booth_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   booth_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request and waits (bounded) for done; n=1 is the cycle after the accepting edge.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 0;
      bcnt  = 0;
      for (int n = 1; n <= 40; n++) begin
         if (done) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      dividend = 8'd0;
      divisor = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
      n_checks++; if (quotient !== 8'h00) begin n_fail++; $display("FAIL reset_quotient got %0h want 00", quotient); end
      n_checks++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL reset_remainder got %0h want 00", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, bcnt;
      run_div(8'd100, 8'd7, lat, bcnt);
      n_checks++; if (lat != 10) begin n_fail++; $display("FAIL basic_latency got %0d want 10", lat); end
      n_checks++; if (bcnt != 9) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 9", bcnt); end
      n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_quotient got %0h want 0e", quotient); end
      n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL basic_remainder got %0h want 02", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz got %0b want 0", div_by_zero); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done got %0b want 0", busy); end
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %0b want 0", done); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_hold got %0h want 0e", quotient); end
   endtask

   task automatic test_signs();
      logic [7:0] va [7];
      logic [7:0] vb [7];
      logic [7:0] vq [7];
      logic [7:0] vr [7];
      int lat, bcnt;
      va = '{8'h9C, 8'h64, 8'h9C, 8'h80, 8'h00, 8'h07, 8'hFF};
      vb = '{8'h07, 8'hF9, 8'hF9, 8'hFF, 8'h05, 8'h64, 8'h02};
      vq = '{8'hF2, 8'hF2, 8'h0E, 8'h80, 8'h00, 8'h00, 8'h00};
      vr = '{8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h07, 8'hFF};
      for (int i = 0; i < 7; i++) begin
         run_div(va[i], vb[i], lat, bcnt);
         n_checks++; if (lat != 10) begin n_fail++; $display("FAIL signs_latency[%0d] got %0d want 10", i, lat); end
         n_checks++; if (quotient !== vq[i]) begin n_fail++; $display("FAIL signs_quotient[%0d] %0h/%0h got %0h want %0h", i, va[i], vb[i], quotient, vq[i]); end
         n_checks++; if (remainder !== vr[i]) begin n_fail++; $display("FAIL signs_remainder[%0d] %0h/%0h got %0h want %0h", i, va[i], vb[i], remainder, vr[i]); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_zero_divisor();
      int lat, bcnt;
`ifdef BOOTH_DIV_ZERO_CHECK_EN
      run_div(8'd5, 8'd0, lat, bcnt);
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
      n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL zero_quotient got %0h want ff", quotient); end
      n_checks++; if (remainder !== 8'h05) begin n_fail++; $display("FAIL zero_remainder got %0h want 05", remainder); end
      n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL zero_dbz got %0b want 1", div_by_zero); end
      @(posedge clk);
      #1;
      run_div(8'hFB, 8'd0, lat, bcnt);
      n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL zero_neg_quotient got %0h want ff", quotient); end
      n_checks++; if (remainder !== 8'hFB) begin n_fail++; $display("FAIL zero_neg_remainder got %0h want fb", remainder); end
      @(posedge clk);
      #1;
      run_div(8'd9, 8'd3, lat, bcnt);
      n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL zero_after_quotient got %0h want 03", quotient); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL zero_after_dbz got %0b want 0", div_by_zero); end
`else
      run_div(8'd5, 8'd0, lat, bcnt);
      n_checks++; if (lat != 10) begin n_fail++; $display("FAIL zero_latency got %0d want 10", lat); end
      n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL zero_quotient got %0h want ff", quotient); end
      n_checks++; if (remainder !== 8'h05) begin n_fail++; $display("FAIL zero_remainder got %0h want 05", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL zero_dbz got %0b want 0", div_by_zero); end
      @(posedge clk);
      #1;
      run_div(8'hFB, 8'd0, lat, bcnt);
      n_checks++; if (quotient !== 8'h01) begin n_fail++; $display("FAIL zero_neg_quotient got %0h want 01", quotient); end
      n_checks++; if (remainder !== 8'hFB) begin n_fail++; $display("FAIL zero_neg_remainder got %0h want fb", remainder); end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_busy_ignore();
      int dcnt;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd5;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dcnt = 0;
      for (int n = 0; n < 20; n++) begin
         if (done) dcnt++;
         @(posedge clk);
         #1;
      end
      n_checks++; if (dcnt != 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
      n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL ignore_quotient got %0h want 0e", quotient); end
      n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL ignore_remainder got %0h want 02", remainder); end
   endtask

   task automatic test_reset_mid();
      int saw_done;
      int lat, bcnt;
      saw_done = 0;
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %0b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %0b want 0", busy); end
      n_checks++; if (quotient !== 8'h00) begin n_fail++; $display("FAIL midreset_quotient got %0h want 00", quotient); end
      n_checks++; if (remainder !== 8'h00) begin n_fail++; $display("FAIL midreset_remainder got %0h want 00", remainder); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1;
      end
      n_checks++; if (saw_done != 0) begin n_fail++; $display("FAIL midreset_no_done got %0d want 0", saw_done); end
      run_div(8'd27, 8'd4, lat, bcnt);
      n_checks++; if (lat != 10) begin n_fail++; $display("FAIL midreset_after_latency got %0d want 10", lat); end
      n_checks++; if (quotient !== 8'd6) begin n_fail++; $display("FAIL midreset_after_quotient got %0h want 06", quotient); end
      n_checks++; if (remainder !== 8'd3) begin n_fail++; $display("FAIL midreset_after_remainder got %0h want 03", remainder); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      run_div(8'd77, 8'd10, lat, bcnt);
      n_checks++; if (quotient !== 8'd7) begin n_fail++; $display("FAIL b2b_first_quotient got %0h want 07", quotient); end
      n_checks++; if (remainder !== 8'd7) begin n_fail++; $display("FAIL b2b_first_remainder got %0h want 07", remainder); end
      @(negedge clk);
      dividend = 8'd9;
      divisor  = 8'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done got %0b want 0", busy); end
      n_checks++; if (quotient !== 8'd7) begin n_fail++; $display("FAIL b2b_hold_quotient got %0h want 07", quotient); end
      run_div(8'd9, 8'd3, lat, bcnt);
      n_checks++; if (lat != 10) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 10", lat); end
      n_checks++; if (quotient !== 8'd3) begin n_fail++; $display("FAIL b2b_second_quotient got %0h want 03", quotient); end
      n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_second_remainder got %0h want 00", remainder); end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_zero_divisor();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
